// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, types and helpers for the pontos_flutuantes adder.
// Word layout {sign, exp[EXP_W-1:0], frac[MANT_W-1:0]}, exponent bias BIAS.
// Only the default widths (32-bit word) are validated.
package fp_pkg;

    localparam int unsigned EXP_W  = 6;
    localparam int unsigned MANT_W = 25;
    localparam int unsigned BIAS   = 31;
    localparam int unsigned WORD_W = 1 + EXP_W + MANT_W;

    localparam int unsigned SIG_W  = MANT_W + 1;   // significand with hidden 1
    localparam int unsigned ALN_W  = SIG_W + 3;    // + guard, round, sticky
    localparam int unsigned SUM_W  = ALN_W + 1;    // + carry out of the adder
    localparam int unsigned RND_W  = SIG_W + 1;    // significand + rounding carry
    localparam int unsigned LZC_W  = 5;            // counts 0..SUM_W
    localparam int unsigned EXPI_W = EXP_W + 2;    // signed working exponent

    localparam int unsigned ST_W         = 4;
    localparam int unsigned ST_EXACT     = 3;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_UNDERFLOW = 1;
    localparam int unsigned ST_INEXACT   = 0;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp_t;

    typedef enum logic [2:0] {
        S_LOAD,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND
    } state_t;

    // exp == 0 encodes zero; the fraction field carries no meaning then
    function automatic fp_t fp_flush(input fp_t v);
        fp_t r;
        r = v;
        if (v.exp == '0) begin
            r.frac = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter over the adder result.
// Ports:
//   value   : SUM_W-bit input word
//   count_c : number of leading zeros (SUM_W when value is zero)
module fp_lzc
    import fp_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [LZC_W-1:0] count_c
);

    logic found;

    // Priority scan from the MSB; first set bit wins.
    always_comb begin
        count_c = LZC_W'(SUM_W);
        found   = 1'b0;
        for (int i = SUM_W - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count_c = LZC_W'(SUM_W - 1 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pontos_flutuantes.sv
// pontos_flutuantes: five-state iterative adder for the custom 32-bit float
// format {sign, exp[5:0] bias 31, frac[24:0]} with hidden leading one.
// Operands are sampled every fifth clock (S_LOAD); the registered sum and
// status appear four clocks later and are held until the next update.
// Ports:
//   clock_100kHz : system clock, rising edge
//   reset        : asynchronous, active-low
//   op_A_in      : operand A
//   op_B_in      : operand B
//   data_out     : registered sum
//   status_out   : {EXACT, OVERFLOW, UNDERFLOW, INEXACT}
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even; the
// default build truncates toward zero (INEXACT still reported).
module pontos_flutuantes
    import fp_pkg::*;
(
    input  logic              clock_100kHz,
    input  logic              reset,
    input  logic [WORD_W-1:0] op_A_in,
    input  logic [WORD_W-1:0] op_B_in,
    output logic [WORD_W-1:0] data_out,
    output logic [ST_W-1:0]   status_out
);

    state_t state, state_nxt;

    fp_t               a_q, b_q;
    logic              x_sign_q, eff_sub_q;
    logic [EXP_W-1:0]  x_exp_q;
    logic [ALN_W-1:0]  x_aln_q, y_aln_q;
    logic [SUM_W-1:0]  sum_q;
    logic [ALN_W-1:0]  norm_sig_q;
    logic [EXPI_W-1:0] norm_exp_q;
    logic              zero_q;

    // Align-stage signals
    fp_t                x_op, y_op;
    logic [SIG_W-1:0]   sig_y;
    logic [EXP_W-1:0]   exp_diff;
    logic [2*ALN_W-1:0] y_ext;
    logic [ALN_W-1:0]   x_aln_d, y_aln_d;

    // Add / normalise / round signals
    logic [SUM_W-1:0]  sum_d;
    logic [LZC_W-1:0]  lz_c;
    logic [ALN_W-1:0]  norm_sig_d;
    logic [EXPI_W-1:0] norm_exp_d;
    logic              round_up;
    logic              grs_nz;
    logic [RND_W-1:0]  rounded;
    logic [MANT_W-1:0] fin_frac;
    logic [EXPI_W-1:0] fin_exp;
    fp_t               res_d;
    logic [ST_W-1:0]   status_d;

    // State register
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a fixed ring, one result per pass
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  state_nxt = S_ALIGN;
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Order by magnitude, then shift Y right with sticky collection
    always_comb begin
        if ({a_q.exp, a_q.frac} >= {b_q.exp, b_q.frac}) begin
            x_op = a_q;
            y_op = b_q;
        end else begin
            x_op = b_q;
            y_op = a_q;
        end
        sig_y    = {|y_op.exp, y_op.frac};
        exp_diff = x_op.exp - y_op.exp;
        x_aln_d  = {|x_op.exp, x_op.frac, 3'b000};
        // Lower half of y_ext catches every bit shifted past the sticky slot
        y_ext    = {sig_y, 3'b000, {ALN_W{1'b0}}} >> exp_diff;
        if (exp_diff >= EXP_W'(ALN_W)) begin
            y_aln_d = {{(ALN_W-1){1'b0}}, |sig_y};
        end else begin
            y_aln_d = {y_ext[2*ALN_W-1:ALN_W+1], y_ext[ALN_W] | (|y_ext[ALN_W-1:0])};
        end
    end

    // Magnitude add or subtract; X >= Y so subtraction never goes negative
    always_comb begin
        if (eff_sub_q) begin
            sum_d = {1'b0, x_aln_q} - {1'b0, y_aln_q};
        end else begin
            sum_d = {1'b0, x_aln_q} + {1'b0, y_aln_q};
        end
    end

    fp_lzc u_lzc (
        .value   (sum_q),
        .count_c (lz_c)
    );

    // Normalise: one-bit right shift on carry, else left shift by lzc-1
    always_comb begin
        if (sum_q[SUM_W-1]) begin
            norm_sig_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            norm_exp_d = EXPI_W'(x_exp_q) + EXPI_W'(1);
        end else begin
            norm_sig_d = sum_q[ALN_W-1:0] << (lz_c - LZC_W'(1));
            norm_exp_d = EXPI_W'(x_exp_q) - EXPI_W'(lz_c) + EXPI_W'(1);
        end
    end

    // Round, renormalise on mantissa carry, classify
    always_comb begin
        grs_nz = |norm_sig_q[2:0];
`ifdef ROUND_NEAREST_EN
        round_up = norm_sig_q[2] & (norm_sig_q[1] | norm_sig_q[0] | norm_sig_q[3]);
`else
        round_up = 1'b0;
`endif
        rounded = {1'b0, norm_sig_q[ALN_W-1:3]} + RND_W'(round_up);
        if (rounded[SIG_W]) begin
            fin_frac = rounded[MANT_W:1];
            fin_exp  = norm_exp_q + EXPI_W'(1);
        end else begin
            fin_frac = rounded[MANT_W-1:0];
            fin_exp  = norm_exp_q;
        end

        res_d    = '0;
        status_d = '0;
        if (zero_q) begin
            status_d[ST_EXACT] = 1'b1;
        end else if ($signed(fin_exp) > $signed(EXPI_W'(EXP_MAX))) begin
            res_d.sign             = x_sign_q;
            res_d.exp              = EXP_MAX;
            res_d.frac             = '1;
            status_d[ST_OVERFLOW]  = 1'b1;
            status_d[ST_INEXACT]   = 1'b1;
        end else if ($signed(fin_exp) < $signed(EXPI_W'(1))) begin
            status_d[ST_UNDERFLOW] = 1'b1;
            status_d[ST_INEXACT]   = 1'b1;
        end else begin
            res_d.sign = x_sign_q;
            res_d.exp  = fin_exp[EXP_W-1:0];
            res_d.frac = fin_frac;
            if (grs_nz) begin
                status_d[ST_INEXACT] = 1'b1;
            end else begin
                status_d[ST_EXACT] = 1'b1;
            end
        end
    end

    // Datapath registers, each loaded only in its own state
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            x_sign_q   <= 1'b0;
            eff_sub_q  <= 1'b0;
            x_exp_q    <= '0;
            x_aln_q    <= '0;
            y_aln_q    <= '0;
            sum_q      <= '0;
            norm_sig_q <= '0;
            norm_exp_q <= '0;
            zero_q     <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    a_q <= fp_flush(fp_t'(op_A_in));
                    b_q <= fp_flush(fp_t'(op_B_in));
                end
                S_ALIGN: begin
                    x_sign_q  <= x_op.sign;
                    eff_sub_q <= x_op.sign ^ y_op.sign;
                    x_exp_q   <= x_op.exp;
                    x_aln_q   <= x_aln_d;
                    y_aln_q   <= y_aln_d;
                end
                S_ADD: begin
                    sum_q <= sum_d;
                end
                S_NORM: begin
                    norm_sig_q <= norm_sig_d;
                    norm_exp_q <= norm_exp_d;
                    zero_q     <= (sum_q == '0);
                end
                S_ROUND: begin
                    data_out   <= res_d;
                    status_out <= status_d;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pontos_flutuantes.sv
// tb_pontos_flutuantes: directed table, hand-written timing sequences and a
// randomized run against an exact-integer reference of the float addition.
module tb_pontos_flutuantes;

`ifdef ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clock_100kHz;
    logic        reset;
    logic [31:0] op_A_in;
    logic [31:0] op_B_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_cmp = 0;
    int n_bad = 0;

    initial clock_100kHz = 1'b0;
    always #5 clock_100kHz = ~clock_100kHz;

    pontos_flutuantes dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .op_A_in      (op_A_in),
        .op_B_in      (op_B_in),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  st;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    // Exact sum on integers scaled by 2^56, then rounded/classified.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] d, output logic [3:0] st);
        logic [127:0] ma, mb, mag, mant, rem, half;
        logic         s;
        int           p, k, e;
        ma = (a[30:25] == 6'd0) ? 128'd0 : (128'({1'b1, a[24:0]}) << a[30:25]);
        mb = (b[30:25] == 6'd0) ? 128'd0 : (128'({1'b1, b[24:0]}) << b[30:25]);
        if (a[31] == b[31]) begin
            mag = ma + mb;
            s   = a[31];
        end else if (ma >= mb) begin
            mag = ma - mb;
            s   = a[31];
        end else begin
            mag = mb - ma;
            s   = b[31];
        end
        if (mag == 128'd0) begin
            d  = 32'h0;
            st = 4'b1000;
            return;
        end
        p = 0;
        for (int i = 127; i >= 0; i--) begin
            if (mag[i]) begin
                p = i;
                break;
            end
        end
        e = p - 25;
        if (p >= 25) begin
            k    = p - 25;
            mant = mag >> k;
            rem  = mag & ((128'd1 << k) - 128'd1);
        end else begin
            k    = 0;
            mant = mag << (25 - p);
            rem  = 128'd0;
        end
        if (RNE && k > 0) begin
            half = 128'd1 << (k - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
        end
        if (mant[26]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e > 63) begin
            d  = {s, 6'h3F, 25'h1FFFFFF};
            st = 4'b0101;
        end else if (e < 1) begin
            d  = 32'h0;
            st = 4'b0011;
        end else begin
            d  = {s, 6'(e), mant[24:0]};
            st = (rem != 128'd0) ? 4'b0001 : 4'b1000;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] d_exp, input logic [3:0] st_exp);
        n_cmp++;
        if (data_out !== d_exp || status_out !== st_exp) begin
            n_bad++;
            $display("FAIL %s: data_out=%h status_out=%b, expected data_out=%h status_out=%b",
                     name, data_out, status_out, d_exp, st_exp);
        end
    endtask

    // Called just after an update edge (or after reset release): the next
    // edge samples the operands, the fifth edge publishes the result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        op_A_in = a;
        op_B_in = b;
        repeat (5) @(posedge clock_100kHz);
        #1;
    endtask

    logic [31:0]  ra, rb, ed;
    logic [3:0]   es;
    int unsigned  mode, ea, eb;

    initial begin
        vecs[0]  = '{"one_plus_two",    32'h3E000000, 32'h40000000, 32'h41000000, 4'b1000};
        vecs[1]  = '{"neg_sum",         32'hBF000000, 32'hC0800000, 32'hC2000000, 4'b1000};
        vecs[2]  = '{"cancel",          32'h40800000, 32'hC0800000, 32'h00000000, 4'b1000};
        vecs[3]  = '{"cancel_swap",     32'hC0800000, 32'h40800000, 32'h00000000, 4'b1000};
        vecs[4]  = '{"overflow",        32'h7E000000, 32'h7E000000, 32'h7FFFFFFF, 4'b0101};
        vecs[5]  = '{"underflow",       32'h02000001, 32'h82000000, 32'h00000000, 4'b0011};
        vecs[6]  = '{"sticky_only",     32'h3E000000, 32'h02000000, 32'h3E000000, 4'b0001};
        vecs[7]  = '{"zero_a",          32'h00000000, 32'h40800000, 32'h40800000, 4'b1000};
        vecs[8]  = '{"zero_b_flushed",  32'hC0800000, 32'h00123456, 32'hC0800000, 4'b1000};
        vecs[9]  = '{"zero_zero",       32'h01FFFFFF, 32'h80000000, 32'h00000000, 4'b1000};
        vecs[10] = '{"deep_cancel",     32'h40000001, 32'hC0000000, 32'h0E000000, 4'b1000};
        vecs[11] = '{"near_ovf_sticky", 32'h7E000000, 32'h3E000000, 32'h7E000000, 4'b0001};
        vecs[12] = '{"min_exp_double",  32'h02000000, 32'h02000000, 32'h04000000, 4'b1000};

        reset   = 1'b0;
        op_A_in = 32'h0;
        op_B_in = 32'h0;
        repeat (3) @(posedge clock_100kHz);
        #1;
        check("reset_state", 32'h0, 4'b0000);
        @(negedge clock_100kHz);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b);
            check(vecs[i].name, vecs[i].d, vecs[i].st);
        end

        // Inputs changed after the sample edge must not matter; output holds.
        op_A_in = 32'h3E000000;
        op_B_in = 32'h40000000;
        @(posedge clock_100kHz);
        #1;
        op_A_in = 32'h7E000000;
        op_B_in = 32'h7E000000;
        repeat (3) @(posedge clock_100kHz);
        #1;
        check("hold_prev", vecs[NV-1].d, vecs[NV-1].st);
        @(posedge clock_100kHz);
        #1;
        check("ignore_late_inputs", 32'h41000000, 4'b1000);

        // Reset in the middle of a pass: immediate clear, no partial result.
        op_A_in = 32'h3E000000;
        op_B_in = 32'h40000000;
        repeat (2) @(posedge clock_100kHz);
        #1;
        reset = 1'b0;
        #1;
        check("reset_async", 32'h0, 4'b0000);
        repeat (2) @(posedge clock_100kHz);
        @(negedge clock_100kHz);
        reset   = 1'b1;
        op_A_in = 32'hBF000000;
        op_B_in = 32'hC0800000;
        repeat (4) @(posedge clock_100kHz);
        #1;
        check("no_partial", 32'h0, 4'b0000);
        @(posedge clock_100kHz);
        #1;
        check("first_after_reset", 32'hC2000000, 4'b1000);

        // Randomized operands, biased toward cancellation, zeros, overflow, ties.
        for (int i = 0; i < 300; i++) begin
            mode = $urandom_range(4, 0);
            ea   = $urandom_range(63, 1);
            ra   = {1'($urandom), 6'(ea), 25'($urandom)};
            case (mode)
                0: rb = $urandom;
                1: begin
                    eb = ea + $urandom_range(1, 0);
                    if (eb > 63) eb = 63;
                    rb = {~ra[31], 6'(eb), ra[24:0] ^ 25'($urandom_range(255, 0))};
                end
                2: begin
                    ra = {1'($urandom), 6'd0, 25'($urandom)};
                    rb = $urandom;
                end
                3: begin
                    ea = $urandom_range(63, 56);
                    eb = $urandom_range(63, 50);
                    ra = {1'($urandom), 6'(ea), 25'($urandom)};
                    rb = {1'($urandom), 6'(eb), 25'($urandom)};
                end
                default: begin
                    ea = $urandom_range(63, 27);
                    ra = {1'($urandom), 6'(ea), 25'($urandom)};
                    rb = {ra[31], 6'(ea - 26), 25'd0};
                end
            endcase
            if ($urandom_range(1, 0) == 1) begin
                ed = ra;
                ra = rb;
                rb = ed;
            end
            ref_add(ra, rb, ed, es);
            run_op(ra, rb);
            check($sformatf("rand%0d a=%h b=%h", i, ra, rb), ed, es);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
